serial_magnitude_comparator: RTL and testbench
==============================================

# serial_magnitude_comparator

Multi-cycle magnitude comparator for WIDTH-bit unsigned operands, built on a single 4-bit compare slice (eq/gt/sm) that is time-shared across nibbles. A start/done handshake sequences the slice MSB-nibble first and stops at the first differing nibble. It sits beside the combinational 4-bit comparator in the combinational_logic library. Wide compares use this block when area matters more than latency.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of 4 and at least 4. NIB = WIDTH/4.
- EARLY_EXIT, 1: 1 = finish at the first differing nibble; 0 = always examine all NIB nibbles, but the result is still decided by the most significant differing nibble.
- clk  input  1  rising-edge clock; one clock domain only.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a compare; sampled only when the block is not busy.
- a  input  WIDTH  operand A, unsigned; captured on the accepted start edge.
- b  input  WIDTH  operand B, unsigned; captured on the accepted start edge.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse; eq/gt/sm are valid from this cycle on.
- eq  output  1  a == b.
- gt  output  1  a > b.
- sm  output  1  a < b.
- nib_cnt  output  clog2(NIB+1)  number of nibbles examined in the last compare.

## Operation
- FSM states are IDLE, RUN and DONE. All outputs and state are registered.
- Reset (asynchronous, rst_n=0):
  - state is IDLE and the internal nibble index is 0;
  - busy, done, eq, gt and sm are 0, and nib_cnt is 0;
  - operand registers are cleared.
- IDLE or DONE with start=1:
  - capture a and b into internal registers;
  - set idx = NIB-1 and go to RUN;
  - clear eq, gt, sm and nib_cnt to 0.
- RUN, each cycle: compare the nibble pair A[4*idx+3:4*idx] and B[4*idx+3:4*idx] with the 4-bit slice, then increment nib_cnt.
  - If the slice reports gt or sm and no decision is latched yet, latch that result.
    - EARLY_EXIT=1: go to DONE.
    - EARLY_EXIT=0: keep going; later nibbles never override a latched decision.
  - If idx == 0, go to DONE. If nothing was latched, set eq=1.
  - Otherwise decrement idx.
- DONE: done=1 for exactly one cycle, then go to IDLE unless start=1 is accepted in that same cycle.
- eq/gt/sm and nib_cnt hold their value from DONE until the next accepted start. They are one-hot, or all 0 while busy or after reset.
- start is ignored while in RUN; there is no queuing.
- Operand inputs are don't-care after the accepting edge; changes to them do not affect a compare in progress.

## Timing
- Accept edge E0 (start=1 in IDLE/DONE): busy=1 from E0.
- With k = nibbles examined, the final compare happens at edge Ek. At Ek: busy=0, done=1 and results are valid, for the cycle following Ek.
- k ranges from 1 to NIB when EARLY_EXIT=1 and is always NIB when EARLY_EXIT=0. Start-to-done latency is therefore k cycles.
- Back-to-back throughput: start held high in the DONE cycle is accepted. One compare then takes k+1 cycles with no idle gap; done and busy are never high together.
- Reset mid-RUN: the operation is abandoned immediately, with no done pulse. Outputs return to reset values asynchronously.
- Slice is purely combinational between the operand registers and the result registers, so there is one nibble compare per clock.

## Test plan
- Equal operands: WIDTH=16, a=b=16'h1234, start 1 cycle -> busy for 4 cycles, then done with eq=1, gt=sm=0, nib_cnt=4.
- MSB decides: a=16'h8000, b=16'h7FFF -> done 1 cycle after E0 with gt=1, nib_cnt=1. With EARLY_EXIT=0 -> gt=1 and nib_cnt=4; the lower nibbles (0 vs F) do not flip the result.
- LSB decides: a=16'h1234, b=16'h1235 -> sm=1 after 4 cycles, nib_cnt=4.
- Start in RUN ignored: start a=16'h0001/b=16'h0000, pulse start again at cycle 2 with different operands -> exactly one done at cycle 4 with gt=1. Changing a/b after E0 has no effect.
- Back-to-back: hold start=1 through the DONE cycle with a=16'hF000/b=16'h0FFF, then a=b=16'h0000 -> done twice (gt, then eq), no idle cycle between busy periods, busy and done never both high.
- Reset mid-operation: drop rst_n at cycle 2 of a 4-nibble compare -> busy, done and eq/gt/sm are 0 immediately, no done pulse. After release a new start completes normally.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle unsigned magnitude comparator that time-shares one 4-bit
// eq/gt/sm slice across the operand nibbles, most significant nibble first.
module serial_magnitude_comparator #(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1,
  parameter int NIB        = WIDTH / 4,
  parameter int CW         = $clog2(NIB + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             sm,
  output logic [CW-1:0]    nib_cnt
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] a_reg, a_n, b_reg, b_n;
  logic             busy_n, done_n, eq_n, gt_n, sm_n;
  logic [CW-1:0]    nib_cnt_n;

  logic [3:0] a_nib, b_nib;
  logic       slice_gt, slice_sm, finish;

  // The shared 4-bit slice, looking at the nibble pair selected by idx.
  assign a_nib    = a_reg[4*idx +: 4];
  assign b_nib    = b_reg[4*idx +: 4];
  assign slice_gt = (a_nib > b_nib);
  assign slice_sm = (a_nib < b_nib);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      sm      <= 1'b0;
      nib_cnt <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      a_reg   <= a_n;
      b_reg   <= b_n;
      busy    <= busy_n;
      done    <= done_n;
      eq      <= eq_n;
      gt      <= gt_n;
      sm      <= sm_n;
      nib_cnt <= nib_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    a_n       = a_reg;
    b_n       = b_reg;
    busy_n    = busy;
    done_n    = 1'b0;
    eq_n      = eq;
    gt_n      = gt;
    sm_n      = sm;
    nib_cnt_n = nib_cnt;
    finish    = 1'b0;

    case (state)
      IDLE, DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
        if (start) begin
          a_n       = a;
          b_n       = b;
          idx_n     = IW'(NIB - 1);
          state_n   = RUN;
          busy_n    = 1'b1;
          eq_n      = 1'b0;
          gt_n      = 1'b0;
          sm_n      = 1'b0;
          nib_cnt_n = '0;
        end
      end

      RUN: begin
        nib_cnt_n = nib_cnt + CW'(1);
        // gt/sm double as the latched decision; once set, lower nibbles never override it.
        if (!(gt || sm) && (slice_gt || slice_sm)) begin
          gt_n = slice_gt;
          sm_n = slice_sm;
          if (EARLY_EXIT != 0) finish = 1'b1;
        end
        if (idx == '0) finish = 1'b1;

        if (finish) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          eq_n    = !(gt_n || sm_n);
        end else begin
          idx_n = idx - IW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator: one early-exit and one
// full-scan instance, directed vectors with hand-computed results.
module tb_serial_magnitude_comparator;

  typedef struct {
    bit eq;
    bit gt;
    bit sm;
    int k;
    int acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start1, start0;
  logic [15:0] a1, b1, a0, b0;
  logic        busy1, done1, eq1, gt1, sm1;
  logic        busy0, done0, eq0, gt0, sm0;
  logic [2:0]  cnt1, cnt0;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q1[$];
  exp_t q0[$];

  serial_magnitude_comparator #(.WIDTH(16), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .sm(sm1), .nib_cnt(cnt1)
  );

  serial_magnitude_comparator #(.WIDTH(16), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .sm(sm0), .nib_cnt(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Monitors: pop the oldest expectation whenever done is seen.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checkOutput("dut1_busy_and_done", int'(busy1 & done1), 0);
      if (done1) begin
        if (q1.size() == 0) begin
          checkOutput("dut1_unexpected_done", 1, 0);
        end else begin
          e = q1.pop_front();
          checkOutput("dut1_eq", int'(eq1), int'(e.eq));
          checkOutput("dut1_gt", int'(gt1), int'(e.gt));
          checkOutput("dut1_sm", int'(sm1), int'(e.sm));
          checkOutput("dut1_nib_cnt", int'(cnt1), e.k);
          checkOutput("dut1_latency", cyc - e.acc, e.k);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checkOutput("dut0_busy_and_done", int'(busy0 & done0), 0);
      if (done0) begin
        if (q0.size() == 0) begin
          checkOutput("dut0_unexpected_done", 1, 0);
        end else begin
          e = q0.pop_front();
          checkOutput("dut0_eq", int'(eq0), int'(e.eq));
          checkOutput("dut0_gt", int'(gt0), int'(e.gt));
          checkOutput("dut0_sm", int'(sm0), int'(e.sm));
          checkOutput("dut0_nib_cnt", int'(cnt0), e.k);
          checkOutput("dut0_latency", cyc - e.acc, e.k);
        end
      end
    end
  end

  task automatic waitDone(input bit which);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((which && done1) || (!which && done0)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input bit which, input logic [15:0] av, input logic [15:0] bv,
                               input bit e_eq, input bit e_gt, input bit e_sm, input int k);
    exp_t e;
    @(negedge clk);
    e = '{eq: e_eq, gt: e_gt, sm: e_sm, k: k, acc: cyc + 1};
    if (which) begin
      start1 = 1'b1; a1 = av; b1 = bv; q1.push_back(e);
    end else begin
      start0 = 1'b1; a0 = av; b0 = bv; q0.push_back(e);
    end
    @(negedge clk);
    start1 = 1'b0;
    start0 = 1'b0;
    waitDone(which);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst_n  = 1'b0;
    start1 = 1'b0; start0 = 1'b0;
    a1 = '0; b1 = '0; a0 = '0; b0 = '0;
    #1;
    checkOutput("reset_busy", int'(busy1), 0);
    checkOutput("reset_done", int'(done1), 0);
    checkOutput("reset_result", int'({eq1, gt1, sm1}), 0);
    checkOutput("reset_nib_cnt", int'(cnt1), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1, 16'h1234, 16'h1234, 1, 0, 0, 4);
    applyStimulus(1, 16'h8000, 16'h7FFF, 0, 1, 0, 1);
    applyStimulus(1, 16'h1234, 16'h1235, 0, 0, 1, 4);
    applyStimulus(1, 16'h00F0, 16'h0100, 0, 0, 1, 2);
    applyStimulus(0, 16'h8000, 16'h7FFF, 0, 1, 0, 4);
    applyStimulus(0, 16'h1234, 16'h1235, 0, 0, 1, 4);
    applyStimulus(0, 16'h0000, 16'h0000, 1, 0, 0, 4);

    // Start pulsed mid-RUN with new operands must be ignored.
    @(negedge clk);
    start1 = 1'b1; a1 = 16'h0001; b1 = 16'h0000;
    q1.push_back('{eq: 0, gt: 1, sm: 0, k: 4, acc: cyc + 1});
    @(negedge clk);
    start1 = 1'b0; a1 = 16'h0000; b1 = 16'hFFFF;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    waitDone(1);
    repeat (8) @(negedge clk);

    // Back-to-back: start held through the DONE cycle.
    start1 = 1'b1; a1 = 16'hF000; b1 = 16'h0FFF;
    q1.push_back('{eq: 0, gt: 1, sm: 0, k: 1, acc: cyc + 1});
    @(negedge clk);
    a1 = 16'h0000; b1 = 16'h0000;
    q1.push_back('{eq: 1, gt: 0, sm: 0, k: 4, acc: cyc + 2});
    @(negedge clk);
    checkOutput("b2b_first_done", int'(done1), 1);
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("b2b_no_gap_busy", int'(busy1), 1);
    waitDone(1);
    repeat (3) @(negedge clk);

    // Reset dropped in the second RUN cycle of a 4-nibble compare.
    start1 = 1'b1; a1 = 16'h1234; b1 = 16'h1235;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(busy1), 0);
    checkOutput("midrst_done", int'(done1), 0);
    checkOutput("midrst_result", int'({eq1, gt1, sm1}), 0);
    checkOutput("midrst_nib_cnt", int'(cnt1), 0);
    checkOutput("midrst_dut0_eq", int'(eq0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(1, 16'h1234, 16'h1235, 0, 0, 1, 4);

    repeat (4) @(negedge clk);
    checkOutput("dut1_queue_empty", q1.size(), 0);
    checkOutput("dut0_queue_empty", q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
